// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit owning the HI/LO pair: shift-add multiplier and
// restoring divider sharing one 2*WIDTH accumulator, with a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for iStart; MTHI/MTLO write here directly
// RUN   | one multiply or divide iteration per cycle, WIDTH cycles
// FIX   | sign correction and HI/LO write, raises oDone for the next cycle
module mdu_iterative #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iStart,
  input  logic [2:0]       iOp,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic             oBusy,
  output logic             oDone,
  output logic             oDivByZero,
  output logic [WIDTH-1:0] oHI,
  output logic [WIDTH-1:0] oLO
);

  localparam logic [2:0] OP_MULT = 3'd0;
  localparam logic [2:0] OP_DIV  = 3'd2;
  localparam logic [2:0] OP_DIVU = 3'd3;
  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t state;

  // Multiply: acc = {partial sum, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, remaining dividend / quotient bits}.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opr;
  logic [WIDTH-1:0]   a_raw;
  logic [CNTW-1:0]    cnt;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               dbz;

  logic               op_div;
  logic               op_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    op_div    = (iOp == OP_DIV) || (iOp == OP_DIVU);
    op_signed = (iOp == OP_MULT) || (iOp == OP_DIV);
    a_neg     = op_signed & iA[WIDTH-1];
    b_neg     = op_signed & iB[WIDTH-1];
    a_mag     = a_neg ? -iA : iA;
    b_mag     = b_neg ? -iB : iB;
  end

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opr} : '0);
    mul_next  = {mul_sum, acc[WIDTH-1:1]};

    // Partial remainder stays below the divisor, so WIDTH+1 bits hold the
    // trial and its top bit doubles as the borrow.
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opr};
    div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

    prod_fix  = neg_res ? -acc : acc;
    quo_fix   = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix   = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state      <= S_IDLE;
      cnt        <= '0;
      acc        <= '0;
      opr        <= '0;
      a_raw      <= '0;
      is_div     <= 1'b0;
      neg_res    <= 1'b0;
      neg_rem    <= 1'b0;
      dbz        <= 1'b0;
      oHI        <= '0;
      oLO        <= '0;
      oBusy      <= 1'b0;
      oDone      <= 1'b0;
      oDivByZero <= 1'b0;
    end else begin
      oDone      <= 1'b0;
      oDivByZero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (iStart) begin
            if (!iOp[2]) begin
              state   <= S_RUN;
              cnt     <= '0;
              oBusy   <= 1'b1;
              is_div  <= op_div;
              neg_res <= a_neg ^ b_neg;
              neg_rem <= a_neg;
              dbz     <= op_div && (iB == '0);
              a_raw   <= iA;
              acc     <= {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
              opr     <= op_div ? b_mag : a_mag;
            end else if (iOp == OP_MTHI) begin
              oHI <= iA;
            end else if (iOp == OP_MTLO) begin
              oLO <= iA;
            end
          end
        end
        S_RUN: begin
          acc <= is_div ? div_next : mul_next;
          if (cnt == CNT_LAST) begin
            state <= S_FIX;
          end else begin
            cnt <= cnt + CNTW'(1);
          end
        end
        S_FIX: begin
          if (!is_div) begin
            oHI <= prod_fix[2*WIDTH-1:WIDTH];
            oLO <= prod_fix[WIDTH-1:0];
          end else if (dbz) begin
            // Divide by zero reports the raw dividend, no sign fix-up.
            oHI <= a_raw;
            oLO <= '1;
          end else begin
            oHI <= rem_fix;
            oLO <= quo_fix;
          end
          oBusy      <= 1'b0;
          oDone      <= 1'b1;
          oDivByZero <= is_div & dbz;
          cnt        <= '0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// Bench for mdu_iterative: arithmetic/latency reference model checked every cycle,
// directed corner cases with literal results, then a randomized stimulus phase.
module tb_mdu_iterative;
  localparam int W = 32;

  logic         iCLK, iRST, iStart;
  logic [2:0]   iOp;
  logic [W-1:0] iA, iB;
  logic         oBusy, oDone, oDivByZero;
  logic [W-1:0] oHI, oLO;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  logic [W-1:0] exp_hi, exp_lo, pend_hi, pend_lo;
  logic         exp_busy, exp_done, exp_dbz, pend_dbz;
  int           remaining;

  mdu_iterative #(.WIDTH(W), .CNTW(6)) dut (
    .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iOp(iOp), .iA(iA), .iB(iB),
    .oBusy(oBusy), .oDone(oDone), .oDivByZero(oDivByZero), .oHI(oHI), .oLO(oLO)
  );

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Plain-arithmetic reference for one operation.
  function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint sa, sb;
    logic [63:0] p;
    hi = '0; lo = '0; dz = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
      3'd2: if (b == 0) begin dz = 1'b1; hi = a; lo = '1; end
            else begin lo = 32'(sa / sb); hi = 32'(sa % sb); end
      3'd3: if (b == 0) begin dz = 1'b1; hi = a; lo = '1; end
            else begin lo = a / b; hi = a % b; end
      default: ;
    endcase
  endfunction

  // Transaction-level timing model: result lands W+1 edges after acceptance.
  initial forever begin
    @(posedge iCLK);
    if (iRST) begin
      exp_hi = '0; exp_lo = '0; exp_busy = 1'b0; exp_done = 1'b0; exp_dbz = 1'b0;
      remaining = 0;
    end else begin
      exp_done = 1'b0;
      exp_dbz  = 1'b0;
      if (remaining > 0) begin
        remaining--;
        if (remaining == 0) begin
          exp_hi = pend_hi; exp_lo = pend_lo; exp_busy = 1'b0;
          exp_done = 1'b1; exp_dbz = pend_dbz;
        end
      end else if (iStart) begin
        if (iOp <= 3'd3) begin
          ref_op(iOp, iA, iB, pend_hi, pend_lo, pend_dbz);
          remaining = W + 1;
          exp_busy  = 1'b1;
        end else if (iOp == 3'd4) begin
          exp_hi = iA;
        end else if (iOp == 3'd5) begin
          exp_lo = iA;
        end
      end
    end
  end

  initial forever begin
    @(negedge iCLK);
    if (chk_en) begin
      chk("cyc_hi",   64'(oHI), 64'(exp_hi));
      chk("cyc_lo",   64'(oLO), 64'(exp_lo));
      chk("cyc_busy", 64'(oBusy), 64'(exp_busy));
      chk("cyc_done", 64'(oDone), 64'(exp_done));
      chk("cyc_dbz",  64'(oDivByZero), 64'(exp_dbz));
    end
  end

  task automatic pin(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eh, input logic [31:0] el, input logic ez);
    logic [31:0] h, l;
    logic z;
    ref_op(op, a, b, h, l, z);
    chk({"model_", name}, {h, l}, {eh, el});
    chk({"model_", name, "_dz"}, 64'(z), 64'(ez));
  endtask

  // Called at a negedge; the following posedge is the accept edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    iStart = 1'b1; iOp = op; iA = a; iB = b;
    @(negedge iCLK);
    iStart = 1'b0; iA = $urandom; iB = $urandom;
  endtask

  task automatic wait_done(output int cyc, output int bsy);
    cyc = 0;
    bsy = oBusy ? 1 : 0;
    while (!oDone && cyc < 100) begin
      @(negedge iCLK);
      cyc++;
      if (oBusy) bsy++;
    end
    if (!oDone) chk("done_timeout", 64'(0), 64'(1));
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic ez);
    int c, bz;
    issue(op, a, b);
    wait_done(c, bz);
    chk({name, "_latency"}, 64'(c), 64'(33));
    chk({name, "_busy_len"}, 64'(bz), 64'(33));
    chk({name, "_hilo"}, {oHI, oLO}, {eh, el});
    chk({name, "_dz"}, 64'(oDivByZero), 64'(ez));
  endtask

  function automatic logic [31:0] rnd();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int c, bz, nd;
    iRST = 1'b1; iStart = 1'b0; iOp = '0; iA = '0; iB = '0;
    @(posedge iCLK);
    @(negedge iCLK);
    chk_en = 1'b1;
    chk("rst_hi", 64'(oHI), 64'(0));
    chk("rst_lo", 64'(oLO), 64'(0));
    chk("rst_busy", 64'(oBusy), 64'(0));
    chk("rst_done", 64'(oDone), 64'(0));
    iRST = 1'b0;
    @(negedge iCLK);

    pin("mult",   3'd0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    pin("multu",  3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    pin("div",    3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    pin("divu",   3'd3, 32'hFFFF_FFF9, 32'd2,         32'h0000_0001, 32'h7FFF_FFFC, 1'b0);
    pin("div0",   3'd3, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, 1'b1);
    pin("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0);

    run_op("mult",      3'd0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_op("multu_b2b", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("div",       3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu",      3'd3, 32'hFFFF_FFF9, 32'd2,         32'h0000_0001, 32'h7FFF_FFFC, 1'b0);
    run_op("divu_by0",  3'd3, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, 1'b1);
    run_op("div_ovf",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0);

    iStart = 1'b1; iOp = 3'd4; iA = 32'h1234_5678;
    @(negedge iCLK);
    iStart = 1'b0;
    chk("mthi_hi", 64'(oHI), 64'(32'h1234_5678));
    chk("mthi_busy", 64'(oBusy), 64'(0));
    repeat (3) begin
      @(negedge iCLK);
      chk("mthi_idle", 64'(oBusy), 64'(0));
    end

    issue(3'd0, 32'd1234, 32'd5678);
    repeat (9) @(negedge iCLK);
    iStart = 1'b1; iOp = 3'd5; iA = 32'hDEAD_BEEF;
    @(negedge iCLK);
    iStart = 1'b0;
    wait_done(c, bz);
    chk("mtlo_ignored_hilo", {oHI, oLO}, {32'd0, 32'd7006652});

    issue(3'd2, 32'd100, 32'd7);
    repeat (14) @(negedge iCLK);
    iRST = 1'b1;
    @(negedge iCLK);
    iRST = 1'b0;
    chk("midrst_hi", 64'(oHI), 64'(0));
    chk("midrst_lo", 64'(oLO), 64'(0));
    chk("midrst_busy", 64'(oBusy), 64'(0));
    nd = 0;
    repeat (40) begin
      @(negedge iCLK);
      if (oDone) nd++;
    end
    chk("midrst_no_done", 64'(nd), 64'(0));
    run_op("mult_6x7", 3'd0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      iRST   = ($urandom_range(0, 499) == 0);
      iStart = ($urandom_range(0, 3) == 0);
      iOp    = 3'($urandom_range(0, 7));
      iA     = rnd();
      iB     = rnd();
      @(negedge iCLK);
    end
    iRST = 1'b0; iStart = 1'b0;
    repeat (40) @(negedge iCLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
